dsram_responder: RTL and testbench

DSRAM_RESPONDER -- requirements
Module: dsram_responder

---
 rtl/dsram_responder.sv | 128 ++++++++++++
 tb/tb_dsram_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsram_responder.sv
// Data-SRAM bus responder: 2^AW x 32 backing memory plus an in-order response FIFO with fixed latency.
// Define DSRAM_RAND_DELAY_EN to add LFSR-driven stalls on accept and response.
module dsram_responder #(
  parameter int LATENCY = 2,
  parameter int AW      = 10,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] CD_LOAD = 3'(LATENCY - 1);

  logic [31:0]   mem_q [2**AW];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ent_wr_q    [DEPTH];
  logic          ent_wr_d    [DEPTH];
  logic [31:0]   ent_rdata_q [DEPTH];
  logic [31:0]   ent_rdata_d [DEPTH];
  logic [2:0]    ent_cd_q    [DEPTH];
  logic [2:0]    ent_cd_d    [DEPTH];

  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic          full, head_ready, push, pop;
  logic          stall_acc, stall_rsp;
  logic          unused_addr;

  assign widx        = data_sram_addr[AW+1:2];
  assign unused_addr = ^data_sram_addr[31:AW+2];

  always_comb begin
    unique case (data_sram_size)
      2'd0:    be = 4'b0001 << data_sram_addr[1:0];
      2'd1:    be = data_sram_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

`ifdef DSRAM_RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci taps 16,14,13,11 shifted in at bit 0.
  assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign stall_acc = (lfsr_q[1:0] == 2'b11);
  assign stall_rsp = (lfsr_q[3:2] == 2'b11);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end
`else
  assign stall_acc = 1'b0;
  assign stall_rsp = 1'b0;
`endif

  // A pop in the same cycle never frees a slot for a push: full is judged on the registered count.
  assign full              = (count_q == CW'(DEPTH));
  assign head_ready        = (count_q != '0) && (ent_cd_q[rptr_q] == 3'd0);
  assign data_sram_addr_ok = resetn && data_sram_req && !full && !stall_acc;
  assign data_sram_data_ok = head_ready && !stall_rsp;
  assign data_sram_rdata   = (data_sram_data_ok && !ent_wr_q[rptr_q]) ? ent_rdata_q[rptr_q] : 32'd0;
  assign push              = data_sram_addr_ok;
  assign pop               = data_sram_data_ok;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_wr_d[i]    = ent_wr_q[i];
      ent_rdata_d[i] = ent_rdata_q[i];
      ent_cd_d[i]    = (ent_cd_q[i] != 3'd0) ? ent_cd_q[i] - 3'd1 : 3'd0;
    end
    if (push) begin
      ent_wr_d[wptr_q]    = data_sram_wr;
      ent_rdata_d[wptr_q] = data_sram_wr ? 32'd0 : mem_q[widx];
      ent_cd_d[wptr_q]    = CD_LOAD;
      wptr_d              = wptr_q + PW'(1);
    end
    if (pop) rptr_d = rptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_wr_q[i]    <= 1'b0;
        ent_rdata_q[i] <= 32'd0;
        ent_cd_q[i]    <= 3'd0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_wr_q[i]    <= ent_wr_d[i];
        ent_rdata_q[i] <= ent_rdata_d[i];
        ent_cd_q[i]    <= ent_cd_d[i];
      end
    end
  end

  // Memory survives reset; writes land on the accept edge, enabled lanes only.
  always_ff @(posedge clk) begin
    if (push && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dsram_responder.sv
// Scoreboard bench for dsram_responder: directed write/read, partial write, aliasing,
// back-pressure (LATENCY=4 instance), reset mid-flight and a random phase.
module tb_dsram_responder;

  localparam int LAT = 2;
`ifdef DSRAM_RAND_DELAY_EN
  localparam bit TIMED = 1'b0;
`else
  localparam bit TIMED = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, wr;
  logic [1:0]  sz;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  logic        req4, wr4;
  logic [1:0]  sz4;
  logic [31:0] addr4, wdata4;
  logic        addr_ok4, data_ok4;
  logic [31:0] rdata4;

  always #5 clk = ~clk;

  dsram_responder #(.LATENCY(LAT), .AW(10), .DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(sz),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok), .data_sram_rdata(rdata)
  );

  dsram_responder #(.LATENCY(4), .AW(10), .DEPTH(2)) dut4 (
    .clk(clk), .resetn(resetn),
    .data_sram_req(req4), .data_sram_wr(wr4), .data_sram_size(sz4),
    .data_sram_addr(addr4), .data_sram_wdata(wdata4),
    .data_sram_addr_ok(addr_ok4), .data_sram_data_ok(data_ok4), .data_sram_rdata(rdata4)
  );

  typedef struct {
    logic [31:0] rdata;
    int          due;
    bit          timed;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [1024];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          issued = 0;
  int          resp_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] lanes(input logic [1:0] s, input logic [1:0] a);
    case (s)
      2'd0:    return 4'b0001 << a;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Drives one request until accepted; the expected response is queued on the accept cycle.
  task automatic issue(input bit w, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] wd, input bit use_exp, input logic [31:0] exp_rd);
    exp_t       e;
    bit         done = 1'b0;
    logic [3:0] b;
    logic [9:0] wi;
    req = 1'b1; wr = w; sz = s; addr = a; wdata = wd;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (addr_ok) begin
        done    = 1'b1;
        wi      = a[11:2];
        b       = lanes(s, a[1:0]);
        e.rdata = w ? 32'd0 : (use_exp ? exp_rd : ref_mem[wi]);
        e.due   = cyc + LAT;
        e.timed = TIMED;
        sb.push_back(e);
        issued++;
        if (w) for (int k = 0; k < 4; k++) if (b[k]) ref_mem[wi][8*k +: 8] = wd[8*k +: 8];
      end
    end
    if (!done) chk_eq("accept_timeout", {31'd0, addr_ok}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge clk);
    chk_eq("drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic w4(input logic [31:0] a, input logic [31:0] d);
    bit done = 1'b0;
    req4 = 1'b1; wr4 = 1'b1; sz4 = 2'd2; addr4 = a; wdata4 = d;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (addr_ok4) done = 1'b1;
    end
    if (!done) chk_eq("bp_write_timeout", {31'd0, addr_ok4}, 32'd1);
    @(posedge clk); #1;
    req4 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (data_ok) begin
      if (sb.size() == 0) chk_eq("spurious_data_ok", {31'd0, data_ok}, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk_eq("rdata", rdata, mon_e.rdata);
        if (mon_e.timed) chk_eq("latency", 32'(cyc), 32'(mon_e.due));
        resp_cnt++;
      end
    end else if (rdata !== 32'd0) chk_eq("rdata_idle", rdata, 32'd0);
  end

  initial begin
    int          acc, got, dok_cnt;
    logic [6:0]  exp_aok, exp_dok;
    logic [1:0]  rs;
    logic [31:0] ra;
    bit          rw;

    resetn = 1'b0;
    req = 1'b1; wr = 1'b0; sz = 2'd2; addr = 32'd0; wdata = 32'd0;
    req4 = 1'b0; wr4 = 1'b0; sz4 = 2'd2; addr4 = 32'd0; wdata4 = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_addr_ok", {31'd0, addr_ok}, 32'd0);
    chk_eq("rst_data_ok", {31'd0, data_ok}, 32'd0);
    chk_eq("rst_rdata", rdata, 32'd0);
    chk_eq("rst_count", 32'(dut.count_q), 32'd0);
    req = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // word write then read of the same address on back-to-back edges
    issue(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 1'b0, 32'd0);
    issue(1'b0, 2'd2, 32'h100, 32'd0, 1'b1, 32'hDEADBEEF);
    wait_drain();

    // partial writes merge into the word
    issue(1'b1, 2'd2, 32'h40, 32'h11223344, 1'b0, 32'd0);
    issue(1'b1, 2'd0, 32'h41, 32'h0000AA00, 1'b0, 32'd0);
    issue(1'b1, 2'd1, 32'h42, 32'hBBCC0000, 1'b0, 32'd0);
    issue(1'b0, 2'd2, 32'h40, 32'd0, 1'b1, 32'hBBCCAA44);
    wait_drain();

    // upper address bits alias
    issue(1'b1, 2'd2, 32'h0000_1000, 32'h5A5A5A5A, 1'b0, 32'd0);
    issue(1'b0, 2'd2, 32'h0, 32'd0, 1'b1, 32'h5A5A5A5A);
    wait_drain();

`ifndef DSRAM_RAND_DELAY_EN
    // back-pressure on the LATENCY=4 instance with req held high
    for (int i = 0; i < 4; i++) w4(32'(i * 4), 32'hC0DE0000 + 32'(i));
    repeat (8) @(posedge clk);
    #1;
    exp_aok = 7'b1100011;
    exp_dok = 7'b0110000;
    acc = 0; got = 0;
    req4 = 1'b1; wr4 = 1'b0; addr4 = 32'd0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n < 7) begin
        chk_eq($sformatf("bp_addr_ok_%0d", n), {31'd0, addr_ok4}, {31'd0, exp_aok[n]});
        chk_eq($sformatf("bp_data_ok_%0d", n), {31'd0, data_ok4}, {31'd0, exp_dok[n]});
      end
      if (data_ok4) begin
        chk_eq("bp_order", rdata4, 32'hC0DE0000 + 32'(got));
        got++;
      end
      if (addr_ok4) acc++;
      @(posedge clk); #1;
      addr4 = 32'(acc * 4);
      if (acc == 4) req4 = 1'b0;
    end
    chk_eq("bp_resp_count", 32'(got), 32'd4);
`endif

    // reset with two reads outstanding
    issue(1'b0, 2'd2, 32'h100, 32'd0, 1'b1, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 32'h40, 32'd0, 1'b1, 32'hBBCCAA44);
    resetn = 1'b0;
    sb.delete();
    req = 1'b1;
    #1;
    chk_eq("midrst_addr_ok", {31'd0, addr_ok}, 32'd0);
    req = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    dok_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (data_ok) dok_cnt++;
    end
    chk_eq("midrst_data_ok_seen", 32'(dok_cnt), 32'd0);
    chk_eq("midrst_count", 32'(dut.count_q), 32'd0);
    @(posedge clk); #1;

    // random mix against the reference memory (memory kept across reset)
    issued = 0; resp_cnt = 0;
    for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, 32'h200 + 32'(4 * i), $urandom, 1'b0, 32'd0);
    for (int n = 0; n < 1000; n++) begin
      rw = 1'(($urandom_range(0, 1)));
      rs = 2'($urandom_range(0, 3));
      ra = 32'h200 + 32'(4 * $urandom_range(0, 15)) + (32'($urandom_range(0, 7)) << 12);
      if (rs == 2'd0)      ra = ra + 32'($urandom_range(0, 3));
      else if (rs == 2'd1) ra = ra + 32'(2 * $urandom_range(0, 1));
      issue(rw, rs, ra, $urandom, 1'b0, 32'd0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    wait_drain();
    chk_eq("rand_resp_count", 32'(resp_cnt), 32'(issued));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
